// File: rtl/booth_seq_divider.sv
// booth_seq_divider: multi-cycle signed divider (restoring division on magnitudes).
// One quotient bit per clock, followed by a sign-correction state.
// Handshake: start accepted while busy=0; done pulses for one cycle with results.
// Optional build macro: BOOTH_DIV_EARLY_TERM_EN
//   When defined, |dividend| < |divisor| (divisor non-zero) bypasses the
//   iterations and completes with a 1-cycle latency.
module booth_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;      // partial remainder, one guard bit for the trial sign
    logic [WIDTH-1:0] qdvd_q;     // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic             sign_n_q;
    logic             sign_d_q;
    logic             dz_q;
    logic             ovf_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dz_out_q;
    logic             ovf_out_q;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             early_term;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] qdvd_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    // Operand magnitudes and the bypass decision for the accepting edge
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`ifdef BOOTH_DIV_EARLY_TERM_EN
        early_term   = (divisor != '0) && (dividend_mag < divisor_mag);
`else
        early_term   = 1'b0;
`endif
    end

    // One restoring-division iteration: shift, trial-subtract, keep or restore
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], qdvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
        if (!trial[WIDTH]) begin
            rem_d  = trial;
            qdvd_d = {qdvd_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = shifted;
            qdvd_d = {qdvd_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the magnitude results; zero divisor forces quotient -1
    always_comb begin
        if (dz_q) begin
            quotient_d = '1;
        end else if (sign_n_q ^ sign_d_q) begin
            quotient_d = ~qdvd_q + 1'b1;
        end else begin
            quotient_d = qdvd_q;
        end
        // With a zero divisor every trial succeeds, so rem_q ends as |dividend|
        // and this same correction reproduces the original dividend.
        remainder_d = sign_n_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            qdvd_q      <= '0;
            dsr_q       <= '0;
            sign_n_q    <= 1'b0;
            sign_d_q    <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_out_q    <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_n_q <= dividend[WIDTH-1];
                        sign_d_q <= divisor[WIDTH-1];
                        dz_q     <= (divisor == '0);
                        ovf_q    <= (dividend == MOST_NEG) && (divisor == '1);
                        dsr_q    <= divisor_mag;
                        cnt_q    <= CW'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        if (early_term) begin
                            // Quotient magnitude 0, remainder magnitude |dividend|:
                            // the FIX state then yields quotient 0, remainder = dividend.
                            rem_q   <= {1'b0, dividend_mag};
                            qdvd_q  <= '0;
                            state_q <= FIX;
                        end else begin
                            rem_q   <= '0;
                            qdvd_q  <= dividend_mag;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    qdvd_q <= qdvd_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    quotient_q  <= quotient_d;
                    remainder_q <= remainder_d;
                    dz_out_q    <= dz_q;
                    ovf_out_q   <= ovf_q & ~dz_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_out_q;
    assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed self-checking bench for booth_seq_divider (WIDTH=8).
module tb_booth_seq_divider;

    localparam int W = 8;
`ifdef BOOTH_DIV_EARLY_TERM_EN
    localparam int SMALL_LAT  = 1;
    localparam int SMALL_BUSY = 1;
`else
    localparam int SMALL_LAT  = 9;
    localparam int SMALL_BUSY = 9;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    booth_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle and wait (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt  = busy ? 1 : 0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
            failures++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(8'd100, 8'd7, lat, bc);
        checks++;
        if (lat !== 9) begin
            $display("FAIL basic_latency: got %0d want 9", lat); failures++;
        end
        checks++;
        if (bc !== 9) begin
            $display("FAIL basic_busy_cycles: got %0d want 9", bc); failures++;
        end
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_100_7: got q=%h r=%h dz=%b ov=%b busy=%b, want q=0e r=02 dz=0 ov=0 busy=0",
                     quotient, remainder, div_by_zero, overflow, busy);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
            $display("FAIL done_single_cycle: got done=%b q=%h r=%h, want done=0 q=0e r=02",
                     done, quotient, remainder);
            failures++;
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] va [6] = '{8'h9C, 8'd100, 8'h9C, 8'd127, 8'h80, 8'hFB};
        logic [W-1:0] vb [6] = '{8'd7,  8'hF9,  8'hF9, 8'd1,   8'd1,  8'd2};
        logic [W-1:0] eq [6] = '{8'hF2, 8'hF2,  8'd14, 8'd127, 8'h80, 8'hFE};
        logic [W-1:0] er [6] = '{8'hFE, 8'd2,   8'hFE, 8'd0,   8'd0,  8'hFF};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat, bc);
            checks++;
            if (lat !== 9 || quotient !== eq[i] || remainder !== er[i] || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
                $display("FAIL sign_%0d (%h/%h): got lat=%0d q=%h r=%h dz=%b ov=%b, want lat=9 q=%h r=%h dz=0 ov=0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, overflow, eq[i], er[i]);
                failures++;
            end
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(8'h80, 8'hFF, lat, bc);
        checks++;
        if (lat !== 9 || quotient !== 8'h80 || remainder !== 8'h00 || overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            $display("FAIL overflow_m128_m1: got lat=%0d q=%h r=%h dz=%b ov=%b, want lat=9 q=80 r=00 dz=0 ov=1",
                     lat, quotient, remainder, div_by_zero, overflow);
            failures++;
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(8'd5, 8'd0, lat, bc);
        checks++;
        if (lat !== 9 || quotient !== 8'hFF || remainder !== 8'd5 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL divzero_5_0: got lat=%0d q=%h r=%h dz=%b ov=%b, want lat=9 q=ff r=05 dz=1 ov=0",
                     lat, quotient, remainder, div_by_zero, overflow);
            failures++;
        end
        run_op(8'hFB, 8'd0, lat, bc);
        checks++;
        if (lat !== 9 || quotient !== 8'hFF || remainder !== 8'hFB || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL divzero_m5_0: got lat=%0d q=%h r=%h dz=%b ov=%b, want lat=9 q=ff r=fb dz=1 ov=0",
                     lat, quotient, remainder, div_by_zero, overflow);
            failures++;
        end
        // Flags clear on the next result load
        run_op(8'd9, 8'd3, lat, bc);
        checks++;
        if (quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL flags_clear_9_3: got q=%h r=%h dz=%b ov=%b, want q=03 r=00 dz=0 ov=0",
                     quotient, remainder, div_by_zero, overflow);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        // Start held high and operands changed while busy: both must be ignored
        dividend = 8'd50; divisor = 8'd5;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat !== 9 || quotient !== 8'd14 || remainder !== 8'd2) begin
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=9 q=0e r=02", lat, quotient, remainder);
            failures++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
            failures++;
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat !== 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=9 q=0a r=00", lat, quotient, remainder);
            failures++;
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = -1;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            if (n == 4) begin
                dividend = 8'd3; divisor = 8'd10; start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (dones !== 1 || first !== 9 || quotient !== 8'd14 || remainder !== 8'd2) begin
            $display("FAIL ignore_start: got dones=%0d first=%0d q=%h r=%h, want dones=1 first=9 q=0e r=02",
                     dones, first, quotient, remainder);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        dividend = 8'h9C; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
            failures++;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            $display("FAIL reset_mid_no_done: got %0d active cycles after reset, want 0", dones);
            failures++;
        end
    endtask

    task automatic test_small();
        int lat, bc;
        run_op(8'd3, 8'd10, lat, bc);
        checks++;
        if (lat !== SMALL_LAT || bc !== SMALL_BUSY || quotient !== 8'd0 || remainder !== 8'd3 ||
            div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL small_3_10: got lat=%0d busy=%0d q=%h r=%h dz=%b ov=%b, want lat=%0d busy=%0d q=00 r=03 dz=0 ov=0",
                     lat, bc, quotient, remainder, div_by_zero, overflow, SMALL_LAT, SMALL_BUSY);
            failures++;
        end
        run_op(8'hFD, 8'hF6, lat, bc);
        checks++;
        if (lat !== SMALL_LAT || quotient !== 8'd0 || remainder !== 8'hFD) begin
            $display("FAIL small_m3_m10: got lat=%0d q=%h r=%h, want lat=%0d q=00 r=fd",
                     lat, quotient, remainder, SMALL_LAT);
            failures++;
        end
        // Equal magnitudes never take the short path
        run_op(8'd7, 8'hF9, lat, bc);
        checks++;
        if (lat !== 9 || quotient !== 8'hFF || remainder !== 8'd0) begin
            $display("FAIL equal_7_m7: got lat=%0d q=%h r=%h, want lat=9 q=ff r=00", lat, quotient, remainder);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_small();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
- Multi-cycle signed integer divider; the inverse operation of the team's combinational Booth multiplier.
- Computes quotient and remainder of two's-complement operands using restoring division on magnitudes, one quotient bit per clock, then applies a sign-correction step.
- Sits beside the multiplier in the arithmetic library and uses a start/busy/done handshake, so the datapath owner can reuse the multiplier's operand registers.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; quotient/remainder/flags valid from this cycle.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  output  1  result flag: divisor was 0.
- overflow  output  1  result flag: most-negative / -1.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Capture magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values; |most-negative| = 2^(WIDTH-1) fits.
  - Capture both sign bits, the zero-divisor condition and the overflow condition.
  - Clear the partial remainder (WIDTH+1 bits); set iteration count to WIDTH-1; busy=1; go to CALC.
- CALC, edges E1..E_WIDTH, one iteration per edge:
  - Shift the {partial remainder, dividend magnitude} pair left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After count 0, go to FIX.
- FIX, edge E_(WIDTH+1):
  - Quotient = negate(qmag) if the signs differ, else qmag.
  - Remainder = negate(rmag) if dividend negative, else rmag.
  - Load outputs and flags, done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+1 cycles after start was accepted. For WIDTH=8, done goes high 9 cycles after the start edge.
- done lasts exactly 1 cycle. Outputs hold until the next FIX load or reset.
- start while busy=1 is ignored, with no effect on the running operation.
- start in the done cycle is legal (busy=0) and begins a new operation back-to-back.
- Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0. Full latency still applies.
- Overflow: dividend = -2^(WIDTH-1) and divisor = -1 give quotient = -2^(WIDTH-1) (wrapped), remainder = 0, overflow=1.
- Both flags are cleared on every new result load.
- Operands are sampled only at acceptance; later input changes have no effect.

Optional Feature:
- Macro: BOOTH_DIV_EARLY_TERM_EN.
- Defined: at acceptance, if divisor ≠ 0 and |dividend| < |divisor|, skip CALC and FIX. At edge E1 load quotient=0, remainder=dividend, flags=0, done=1; latency 1 cycle. All other operand cases are unchanged.
- Undefined: every operation takes WIDTH+1 cycles regardless of operands.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start for 1 cycle -> done exactly 9 cycles after the accepting edge; quotient=14, remainder=2; flags 0; busy high for 9 cycles.
- Sign matrix, all with magnitudes 100 and 7:
  - -100/7 -> quotient=-14, remainder=-2.
  - 100/-7 -> quotient=-14, remainder=2.
  - -100/-7 -> quotient=14, remainder=-2.
- -128/-1 -> quotient=-128 (8'h80), remainder=0, overflow=1.
- 5/0 -> quotient=8'hFF, remainder=5, div_by_zero=1.
- Back-to-back: start held high through done -> second operation (50/5 -> 10 r 0) accepted in the done cycle. A start pulse mid-CALC is ignored: no extra done, first result intact.
- Reset at cycle 4 of an operation -> all outputs 0 immediately, no done pulse.
- 3/10 -> quotient=0, remainder=3: done after 1 cycle with BOOTH_DIV_EARLY_TERM_EN defined, after 9 cycles without.
